// File: rtl/perf_counter_mmio.sv
// perf_counter_mmio: MMIO bridge between the CPU data port and the performance counter file.
// Each load/store inside the BASE window becomes one counter-file access cycle, followed
// by a registered one-cycle mem_resp (fixed 2-cycle latency, one access per 3 cycles).
// Optional feature macro: PERF_MMIO_WIDE_EN (64-bit counters exposed as word pairs with a
// high-word read shadow).
module perf_counter_mmio #(
    parameter logic [31:0] BASE    = 32'hFFFF_FF00,
    parameter int unsigned NUM_CNT = 9,
    parameter int unsigned width   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [31:0]      mem_address,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_byte_enable,
    output logic             sel,
    output logic             mem_resp,
    output logic [31:0]      mem_rdata,
    output logic             pc_write,
    output logic [31:0]      pc_address,
    output logic [width-1:0] pc_datain,
    input  logic [width-1:0] pc_dataout
);

`ifdef PERF_MMIO_WIDE_EN
    if (width != 32 && width != 64) begin : gen_width_check
        $error("perf_counter_mmio: width must be 32 or 64");
    end
`else
    if (width != 32) begin : gen_width_check
        $error("perf_counter_mmio: width must be 32 without PERF_MMIO_WIDE_EN");
    end
`endif

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic [5:0]  idx_q;
    logic        op_write_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;

    logic        req;
    logic [31:0] offset;
    logic [5:0]  idx;
    logic [31:0] cnt_num;
    logic        cnt_valid;
    logic        full_store;
    logic [31:0] rd_val;
    logic        unused_offset;

    // Window decode: an unsigned offset below 256 means the address is inside the window.
    assign req           = mem_read | mem_write;
    assign offset        = mem_address - BASE;
    assign sel           = req && (offset < 32'd256);
    assign idx           = offset[7:2];
    assign unused_offset = ^offset[1:0];
    assign full_store    = (be_q == 4'hF);

`ifdef PERF_MMIO_WIDE_EN
    logic        half_hi;
    logic [63:0] dout64;
    logic [63:0] din64;
    logic        shadow_valid_q;
    logic [4:0]  shadow_tag_q;
    logic [31:0] shadow_hi_q;
    logic        shadow_hit;

    assign half_hi    = idx_q[0];
    assign cnt_num    = {27'b0, idx_q[5:1]};
    assign dout64     = 64'(pc_dataout);
    assign shadow_hit = shadow_valid_q && (shadow_tag_q == idx_q[5:1]);
    // Half-word writes merge with the live other half of the counter.
    assign din64      = half_hi ? {wdata_q, dout64[31:0]} : {dout64[63:32], wdata_q};
`else
    assign cnt_num    = {26'b0, idx_q};
`endif

    assign cnt_valid = (cnt_num < NUM_CNT);

    // Next-state logic of the request FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (sel) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Counter-file port: only driven in ACCESS; all-ones address elsewhere hits no counter.
    always_comb begin
        pc_write   = 1'b0;
        pc_address = 32'hFFFF_FFFF;
        pc_datain  = '0;
        rd_val     = 32'h0;
        if (state_q == StAccess && cnt_valid) begin
            pc_address = cnt_num;
            if (op_write_q) begin
                pc_write = full_store;
`ifdef PERF_MMIO_WIDE_EN
                pc_datain = width'(din64);
`else
                pc_datain = width'(wdata_q);
`endif
            end else begin
`ifdef PERF_MMIO_WIDE_EN
                if (half_hi) rd_val = shadow_hit ? shadow_hi_q : dout64[63:32];
                else         rd_val = dout64[31:0];
`else
                rd_val = pc_dataout[31:0];
`endif
            end
        end
    end

    // State register, request latch and registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            op_write_q <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && sel) begin
                idx_q      <= idx;
                op_write_q <= mem_write;
                wdata_q    <= mem_wdata;
                be_q       <= mem_byte_enable;
            end
            if (state_q == StAccess) rdata_q <= rd_val;
        end
    end

`ifdef PERF_MMIO_WIDE_EN
    // High-word shadow: a low-word read snapshots the upper half for a coherent pair read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_valid_q <= 1'b0;
            shadow_tag_q   <= '0;
            shadow_hi_q    <= '0;
        end else if (state_q == StAccess && cnt_valid) begin
            if (!op_write_q && !half_hi) begin
                shadow_valid_q <= 1'b1;
                shadow_tag_q   <= idx_q[5:1];
                shadow_hi_q    <= dout64[63:32];
            end else if (op_write_q && full_store && shadow_hit) begin
                shadow_valid_q <= 1'b0;
            end
        end
    end
`endif

    assign mem_resp  = (state_q == StResp);
    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_perf_counter_mmio.sv
// Self-checking bench for perf_counter_mmio (default narrow build). A simple counter file
// lives in the bench; expected read data and counter contents come from a per-counter
// model array updated by transaction-level rules.
module tb_perf_counter_mmio;

    localparam logic [31:0] BASE    = 32'hFFFF_FF00;
    localparam int unsigned NUM_CNT = 9;
    localparam int unsigned W       = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_read, mem_write;
    logic [31:0]   mem_address, mem_wdata;
    logic [3:0]    mem_byte_enable;
    logic          sel, mem_resp;
    logic [31:0]   mem_rdata;
    logic          pc_write;
    logic [31:0]   pc_address;
    logic [W-1:0]  pc_datain, pc_dataout;

    int n_checks = 0;
    int n_errors = 0;

    perf_counter_mmio #(.BASE(BASE), .NUM_CNT(NUM_CNT), .width(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .sel             (sel),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .pc_write        (pc_write),
        .pc_address      (pc_address),
        .pc_datain       (pc_datain),
        .pc_dataout      (pc_dataout)
    );

    always #5 clk = ~clk;

    // Bench counter file with a side load port for preloading values.
    logic [31:0] cnt [NUM_CNT];
    logic        load_en = 1'b0;
    logic [3:0]  load_idx = '0;
    logic [31:0] load_val = '0;

    always @(posedge clk) begin
        if (pc_write && pc_address < NUM_CNT) cnt[pc_address[3:0]] <= pc_datain;
        if (load_en) cnt[load_idx] <= load_val;
    end

    always_comb begin
        pc_dataout = '0;
        if (pc_address < NUM_CNT) pc_dataout = cnt[pc_address[3:0]];
    end

    // Count write strobes away from the clock edge.
    int          wr_cnt = 0;
    logic [31:0] wr_addr = '0;
    always @(negedge clk) begin
        if (pc_write) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = pc_address;
        end
    end

    logic [31:0] model [NUM_CNT];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input int i, input logic [31:0] v);
        @(negedge clk);
        load_en  = 1'b1;
        load_idx = 4'(i);
        load_val = v;
        @(negedge clk);
        load_en  = 1'b0;
        model[i] = v;
    endtask

    // One complete CPU transaction plus its expected outcome from the model.
    task automatic txn(input string tag, input bit rd, input bit wr, input int idx,
                       input logic [1:0] lo, input logic [31:0] wd, input logic [3:0] be);
        bit          exp_wr;
        logic [31:0] exp_rd;
        logic [31:0] rdata;
        int          lat;
        int          w0;
        exp_wr = wr && (idx < NUM_CNT) && (be == 4'hF);
        exp_rd = (!wr && idx < NUM_CNT) ? model[idx] : 32'h0;
        w0     = wr_cnt;
        rdata  = '0;
        lat    = -1;
        @(negedge clk);
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = BASE + 32'(idx) * 4 + {30'b0, lo};
        mem_wdata       = wd;
        mem_byte_enable = be;
        #1;
        check_eq({tag, "/sel"}, 64'(sel), 64'(1));
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (mem_resp) begin
                lat   = c;
                rdata = mem_rdata;
                break;
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        check_eq({tag, "/latency"}, 64'(lat), 64'(2));
        check_eq({tag, "/rdata"}, 64'(rdata), 64'(exp_rd));
        @(posedge clk);
        #1;
        check_eq({tag, "/resp_pulse"}, 64'(mem_resp), 64'(0));
        check_eq({tag, "/writes"}, 64'(wr_cnt - w0), 64'(exp_wr));
        if (exp_wr) begin
            check_eq({tag, "/wr_addr"}, 64'(wr_addr), 64'(idx));
            model[idx] = wd;
        end
        if (idx < NUM_CNT) check_eq({tag, "/counter"}, 64'(cnt[idx]), 64'(model[idx]));
    endtask

    initial begin
        int w0;
        int resp_seen;
        rst_n           = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst/mem_resp", 64'(mem_resp), 64'(0));
        check_eq("rst/mem_rdata", 64'(mem_rdata), 64'(0));
        check_eq("rst/pc_write", 64'(pc_write), 64'(0));
        check_eq("rst/pc_address", 64'(pc_address), 64'hFFFF_FFFF);
        check_eq("rst/pc_datain", 64'(pc_datain), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < int'(NUM_CNT); i++) preload(i, $urandom);
        preload(0, 32'd5);

        // Directed cases from the basic usage scenarios.
        txn("load_c0", 1'b1, 1'b0, 0, 2'b00, 32'h0, 4'h0);
        txn("store_c2", 1'b0, 1'b1, 2, 2'b00, 32'h1234, 4'hF);
        txn("load_c2", 1'b1, 1'b0, 2, 2'b00, 32'h0, 4'h0);
        txn("partial", 1'b0, 1'b1, 4, 2'b00, 32'hDEAD_BEEF, 4'h3);
        txn("invalid", 1'b1, 1'b0, 16, 2'b00, 32'h0, 4'h0);
        txn("invalid_wr", 1'b0, 1'b1, 9, 2'b00, 32'h55, 4'hF);
        txn("rd_and_wr", 1'b1, 1'b1, 1, 2'b00, 32'hCAFE_0001, 4'hF);
        txn("last_word", 1'b1, 1'b0, 63, 2'b11, 32'h0, 4'h0);

        // Requests that must not be claimed.
        @(negedge clk);
        mem_read    = 1'b1;
        mem_address = BASE - 32'd4;
        #1;
        check_eq("below_win/sel", 64'(sel), 64'(0));
        mem_address = BASE + 32'd256;
        #1;
        check_eq("above_win/sel", 64'(sel), 64'(0));
        resp_seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (mem_resp) resp_seen++;
        end
        check_eq("outside/no_resp", 64'(resp_seen), 64'(0));
        mem_read    = 1'b0;
        mem_address = BASE;
        #1;
        check_eq("no_req/sel", 64'(sel), 64'(0));

        // Reset asserted while a store sits in ACCESS.
        w0 = wr_cnt;
        @(negedge clk);
        mem_write       = 1'b1;
        mem_address     = BASE + 32'd12;
        mem_wdata       = 32'h7777_0000;
        mem_byte_enable = 4'hF;
        @(posedge clk);
        #1;
        check_eq("midrst/access_addr", 64'(pc_address), 64'(3));
        rst_n = 1'b0;
        #1;
        check_eq("midrst/pc_write", 64'(pc_write), 64'(0));
        check_eq("midrst/pc_address", 64'(pc_address), 64'hFFFF_FFFF);
        mem_write = 1'b0;
        resp_seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (mem_resp) resp_seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (mem_resp) resp_seen++;
        end
        check_eq("midrst/no_resp", 64'(resp_seen), 64'(0));
        check_eq("midrst/no_write", 64'(wr_cnt - w0), 64'(0));
        check_eq("midrst/counter", 64'(cnt[3]), 64'(model[3]));
        txn("midrst/reissue", 1'b1, 1'b0, 3, 2'b00, 32'h0, 4'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 40; n++) begin
            int          op;
            int          idx;
            logic [3:0]  be;
            op  = int'($urandom_range(0, 3));
            idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63))
                                              : int'($urandom_range(0, 11));
            be  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            txn("rnd", (op != 1), (op == 1 || op == 2), idx, 2'($urandom), $urandom, be);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
